rf_wb_scheduler: RTL

- Schedules the register file's single write port (WE3/A3/WD3) between two requesters: the in-order pipeline writeback and a long-latency unit (divider/multi-cycle load) that returns results out of order.
- Keeps a per-register pending scoreboard so decode can stall on operands or destinations still owed by the long-latency unit.
- Sits between the writeback stage, the long-latency unit, the decode hazard logic and the register file.

---
 rtl/rf_wb_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_wb_scheduler: arbitrates the register-file write port between pipeline   |
// | writeback and a buffered long-latency unit, with a pending scoreboard.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rf_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p_we,
  input  logic [ADDR_WIDTH-1:0]         p_rd,
  input  logic [DATA_WIDTH-1:0]         p_wd,
  input  logic                          u_valid,
  output logic                          u_ready,
  input  logic [ADDR_WIDTH-1:0]         u_rd,
  input  logic [DATA_WIDTH-1:0]         u_wd,
  input  logic                          iss_valid,
  input  logic [ADDR_WIDTH-1:0]         iss_rd,
  input  logic [ADDR_WIDTH-1:0]         rs1,
  input  logic [ADDR_WIDTH-1:0]         rs2,
  input  logic [ADDR_WIDTH-1:0]         dec_rd,
  output logic                          hazard,
  output logic                          stall_req,
  output logic                          rf_we,
  output logic [ADDR_WIDTH-1:0]         rf_a3,
  output logic [DATA_WIDTH-1:0]         rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int NREG   = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [ADDR_WIDTH-1:0] fifo_rd_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_rd_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wd_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wd_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  stall_q, stall_d;
  logic [NREG-1:0]       pending_q, pending_d;

  logic                  p_req;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_wd;

  assign head_rd = fifo_rd_q[rd_ptr_q];
  assign head_wd = fifo_wd_q[rd_ptr_q];

  // Readiness looks only at the registered count, so a full buffer stays
  // unready even in a cycle where its head drains.
  always_comb begin
    p_req      = p_we & (p_rd != '0);
    fifo_empty = (count_q == '0);
    u_ready    = (count_q != FULL_COUNT);
    push       = u_valid & u_ready & (u_rd != '0);
    pop        = ~p_req & ~fifo_empty;

    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (p_req) begin
      rf_we = 1'b1;
      rf_a3 = p_rd;
      rf_wd = p_wd;
    end else if (!fifo_empty) begin
      rf_we = 1'b1;
      rf_a3 = head_rd;
      rf_wd = head_wd;
    end
    if (rst) begin
      rf_we = 1'b0;
    end
  end

  always_comb begin
    fifo_rd_d = fifo_rd_q;
    fifo_wd_d = fifo_wd_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q] = u_rd;
      fifo_wd_d[wr_ptr_q] = u_wd;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    wait_d = wait_q;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_LIMIT) begin
      wait_d = wait_q + 1'b1;
    end
    stall_d = (wait_q == WAIT_LIMIT);

    // Clear first so a same-cycle issue to the same register wins.
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rd_q <= '{default: '0};
      fifo_wd_q <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      stall_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      fifo_rd_q <= fifo_rd_d;
      fifo_wd_q <= fifo_wd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      pending_q <= pending_d;
    end
  end

  assign hazard     = pending_q[rs1] | pending_q[rs2] | pending_q[dec_rd];
  assign stall_req  = stall_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire
